// File: rtl/trap_sequencer_pkg.sv
// Shared definitions for the machine-mode trap sequencer.
// This package holds the FSM state encoding and the mcause values.
package trap_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSave,
    StMret,
    StRedirect,
    StDrain
  } state_e;

  localparam logic [31:0] CAUSE_ILLEGAL   = 32'd2;
  localparam logic [31:0] CAUSE_LOAD_MIS  = 32'd4;
  localparam logic [31:0] CAUSE_STORE_MIS = 32'd6;
  localparam logic [31:0] CAUSE_MEI       = 32'h8000_000B;

endpackage

// File: rtl/trap_cause_encoder.sv
// Combinational priority encoder from decoder flags to a trap event or an MRET request.
// Priority order is: interrupt, unsupported/illegal, load misaligned, store misaligned, MRET.
module trap_cause_encoder
  import trap_sequencer_pkg::*;
(
  input  logic        ex_valid,
  input  logic        irq_take,
  input  logic        exc_unsupported,
  input  logic        exc_illegal,
  input  logic        exc_load_mis,
  input  logic        exc_store_mis,
  input  logic        mret_req,
  input  logic [31:0] ex_inst,
  input  logic [31:0] ex_mem_addr,
  output logic        take,
  output logic        is_mret,
  output logic [31:0] cause,
  output logic [31:0] tval
);

  always_comb begin
    take    = 1'b0;
    is_mret = 1'b0;
    cause   = '0;
    tval    = '0;
    if (ex_valid) begin
      if (irq_take) begin
        take  = 1'b1;
        cause = CAUSE_MEI;
      end else if (exc_unsupported || exc_illegal) begin
        take  = 1'b1;
        cause = CAUSE_ILLEGAL;
        tval  = ex_inst;
      end else if (exc_load_mis) begin
        take  = 1'b1;
        cause = CAUSE_LOAD_MIS;
        tval  = ex_mem_addr;
      end else if (exc_store_mis) begin
        take  = 1'b1;
        cause = CAUSE_STORE_MIS;
        tval  = ex_mem_addr;
      end else if (mret_req) begin
        // An exception on the same instruction wins, so the MRET request is dropped.
        is_mret = 1'b1;
      end
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Sequences M-mode trap entry and MRET return in four steps: stall, CSR commit, PC redirect, drain flush.
// Events are detected only in the idle state. Any event that arrives while a sequence is running is dropped.
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_inst,
  input  logic [31:0] ex_mem_addr,
  input  logic        exc_unsupported,
  input  logic        exc_illegal,
  input  logic        exc_load_mis,
  input  logic        exc_store_mis,
  input  logic        mret_req,
  input  logic        irq_ext,
  input  logic        csr_mie_global,
  input  logic        csr_meie,
  input  logic [31:0] csr_mtvec,
  input  logic [31:0] csr_mepc,
  output logic        stall,
  output logic        flush,
  output logic        pc_redirect,
  output logic [31:0] pc_target,
  output logic        trap_we,
  output logic        mret_we,
  output logic [31:0] trap_mepc,
  output logic [31:0] trap_mcause,
  output logic [31:0] trap_mtval
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] tval_q, tval_d;
  logic [31:0] target_q, target_d;

  logic        irq_take;
  logic        detect_en;
  logic        take;
  logic        is_mret;
  logic [31:0] enc_cause;
  logic [31:0] enc_tval;

  assign irq_take  = irq_ext & csr_mie_global & csr_meie;
  // Detection is blocked during reset, so the reset cycle cannot raise a combinational stall.
  assign detect_en = ex_valid & (state_q == StIdle) & ~reset;

  trap_cause_encoder u_encoder (
    .ex_valid        (detect_en),
    .irq_take        (irq_take),
    .exc_unsupported (exc_unsupported),
    .exc_illegal     (exc_illegal),
    .exc_load_mis    (exc_load_mis),
    .exc_store_mis   (exc_store_mis),
    .mret_req        (mret_req),
    .ex_inst         (ex_inst),
    .ex_mem_addr     (ex_mem_addr),
    .take            (take),
    .is_mret         (is_mret),
    .cause           (enc_cause),
    .tval            (enc_tval)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pc_d     = pc_q;
    cause_d  = cause_q;
    tval_d   = tval_q;
    target_d = target_q;
    unique case (state_q)
      StIdle: begin
        if (take) begin
          state_d = StSave;
          pc_d    = ex_pc;
          cause_d = enc_cause;
          tval_d  = enc_tval;
        end else if (is_mret) begin
          state_d = StMret;
        end
      end
      StSave: begin
        target_d = {csr_mtvec[31:2], 2'b00};
        state_d  = StRedirect;
      end
      StMret: begin
        target_d = csr_mepc;
        state_d  = StRedirect;
      end
      StRedirect: begin
        cnt_d   = 4'(DRAIN_CYCLES - 1);
        state_d = StDrain;
      end
      StDrain: begin
        if (cnt_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      pc_q     <= '0;
      cause_q  <= '0;
      tval_q   <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pc_q     <= pc_d;
      cause_q  <= cause_d;
      tval_q   <= tval_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    stall       = (state_q != StIdle) | take | is_mret;
    trap_we     = (state_q == StSave);
    mret_we     = (state_q == StMret);
    pc_redirect = (state_q == StRedirect);
    flush       = (state_q == StRedirect) | (state_q == StDrain);
    pc_target   = target_q;
    trap_mepc   = pc_q;
    trap_mcause = cause_q;
    trap_mtval  = tval_q;
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed scenarios followed by random stimulus.
// A timeline reference model (offset from the detect cycle) supplies all expected values.
module tb_trap_sequencer;

  localparam int unsigned D = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_inst, ex_mem_addr;
  logic        exc_unsupported, exc_illegal, exc_load_mis, exc_store_mis;
  logic        mret_req, irq_ext, csr_mie_global, csr_meie;
  logic [31:0] csr_mtvec, csr_mepc;
  logic        stall, flush, pc_redirect, trap_we, mret_we;
  logic [31:0] pc_target, trap_mepc, trap_mcause, trap_mtval;

  always #5 clk = ~clk;

  trap_sequencer #(.DRAIN_CYCLES(D)) dut (
    .clk             (clk),
    .reset           (reset),
    .ex_valid        (ex_valid),
    .ex_pc           (ex_pc),
    .ex_inst         (ex_inst),
    .ex_mem_addr     (ex_mem_addr),
    .exc_unsupported (exc_unsupported),
    .exc_illegal     (exc_illegal),
    .exc_load_mis    (exc_load_mis),
    .exc_store_mis   (exc_store_mis),
    .mret_req        (mret_req),
    .irq_ext         (irq_ext),
    .csr_mie_global  (csr_mie_global),
    .csr_meie        (csr_meie),
    .csr_mtvec       (csr_mtvec),
    .csr_mepc        (csr_mepc),
    .stall           (stall),
    .flush           (flush),
    .pc_redirect     (pc_redirect),
    .pc_target       (pc_target),
    .trap_we         (trap_we),
    .mret_we         (mret_we),
    .trap_mepc       (trap_mepc),
    .trap_mcause     (trap_mcause),
    .trap_mtval      (trap_mtval)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: k = -1 when idle, otherwise the cycle offset from detect (1 .. 2+D).
  int          k = -1;
  bit          m_mret;
  logic [31:0] m_pc, m_cause, m_tval, m_target;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_events();
    ex_valid        = 1'b0;
    exc_unsupported = 1'b0;
    exc_illegal     = 1'b0;
    exc_load_mis    = 1'b0;
    exc_store_mis   = 1'b0;
    mret_req        = 1'b0;
    irq_ext         = 1'b0;
  endtask

  // Inputs are already driven. Check this cycle's outputs, advance the model, then move to the next cycle.
  task automatic step();
    bit          ev, is_trap;
    logic [31:0] c, t;
    #2;
    ev = 1'b0;
    is_trap = 1'b0;
    c = '0;
    t = '0;
    if (k < 0 && !reset && ex_valid) begin
      if (irq_ext && csr_mie_global && csr_meie) begin
        ev = 1'b1; is_trap = 1'b1; c = 32'h8000_000B; t = '0;
      end else if (exc_unsupported || exc_illegal) begin
        ev = 1'b1; is_trap = 1'b1; c = 32'd2; t = ex_inst;
      end else if (exc_load_mis) begin
        ev = 1'b1; is_trap = 1'b1; c = 32'd4; t = ex_mem_addr;
      end else if (exc_store_mis) begin
        ev = 1'b1; is_trap = 1'b1; c = 32'd6; t = ex_mem_addr;
      end else if (mret_req) begin
        ev = 1'b1;
      end
    end
    check_eq("stall", 32'(stall), 32'((k >= 0) || ev));
    check_eq("trap_we", 32'(trap_we), 32'(k == 1 && !m_mret));
    check_eq("mret_we", 32'(mret_we), 32'(k == 1 && m_mret));
    check_eq("pc_redirect", 32'(pc_redirect), 32'(k == 2));
    check_eq("flush", 32'(flush), 32'(k >= 2));
    check_eq("pc_target", pc_target, m_target);
    if (k == 1 && !m_mret) begin
      check_eq("trap_mepc", trap_mepc, m_pc);
      check_eq("trap_mcause", trap_mcause, m_cause);
      check_eq("trap_mtval", trap_mtval, m_tval);
    end
    if (reset) begin
      k = -1;
      m_target = '0;
    end else if (k < 0) begin
      if (ev) begin
        k = 1;
        m_mret = !is_trap;
        m_pc = ex_pc;
        m_cause = c;
        m_tval = t;
      end
    end else begin
      if (k == 1) m_target = m_mret ? csr_mepc : {csr_mtvec[31:2], 2'b00};
      k = (k == int'(2 + D)) ? -1 : k + 1;
    end
    @(posedge clk);
    #1;
  endtask

  // Inputs for the detect cycle are already driven. Run the whole sequence and check its fixed points.
  task automatic run_event(input string tag, input bit is_mret, input logic [31:0] exp_cause,
                           input logic [31:0] exp_target);
    step();
    clear_events();
    if (is_mret) begin
      check_eq({tag, "_mret_we"}, 32'(mret_we), 32'd1);
    end else begin
      check_eq({tag, "_mcause"}, trap_mcause, exp_cause);
    end
    check_eq({tag, "_trap_we"}, 32'(trap_we), 32'(!is_mret));
    step();
    check_eq({tag, "_redirect"}, 32'(pc_redirect), 32'd1);
    check_eq({tag, "_target"}, pc_target, exp_target);
    repeat (D + 1) step();
    check_eq({tag, "_idle"}, 32'(stall | flush), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    clear_events();
    ex_pc = '0; ex_inst = '0; ex_mem_addr = '0;
    csr_mie_global = 1'b0; csr_meie = 1'b0;
    csr_mtvec = '0; csr_mepc = '0;
    m_target = '0; m_mret = 1'b0; m_pc = '0; m_cause = '0; m_tval = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("reset_outs", {27'd0, stall, flush, pc_redirect, trap_we, mret_we}, 32'd0);
    check_eq("reset_target", pc_target, 32'd0);
    step();

    // Illegal instruction with a vectored-looking mtvec; the low bits must be cleared.
    csr_mtvec = 32'h205;
    ex_valid = 1'b1; exc_illegal = 1'b1; ex_pc = 32'h100; ex_inst = 32'hFFFF_FFFF;
    run_event("illegal", 1'b0, 32'd2, 32'h204);
    check_eq("illegal_mepc", trap_mepc, 32'h100);

    // A load-misaligned flag masks a store-misaligned flag on the same instruction.
    ex_valid = 1'b1; exc_load_mis = 1'b1; exc_store_mis = 1'b1; ex_mem_addr = 32'h1003;
    run_event("load_mis", 1'b0, 32'd4, 32'h204);
    check_eq("load_mtval", trap_mtval, 32'h1003);
    ex_valid = 1'b1; exc_store_mis = 1'b1; ex_mem_addr = 32'h2002;
    run_event("store_mis", 1'b0, 32'd6, 32'h204);

    // An enabled interrupt has priority over an illegal flag on the same instruction.
    csr_mie_global = 1'b1; csr_meie = 1'b1;
    ex_valid = 1'b1; irq_ext = 1'b1; exc_illegal = 1'b1; ex_pc = 32'h340; ex_inst = 32'h1234;
    run_event("irq", 1'b0, 32'h8000_000B, 32'h204);
    check_eq("irq_mepc", trap_mepc, 32'h340);
    check_eq("irq_mtval", trap_mtval, 32'h0);
    csr_mie_global = 1'b0;
    ex_valid = 1'b1; irq_ext = 1'b1; exc_illegal = 1'b1;
    run_event("irq_masked", 1'b0, 32'd2, 32'h204);

    // MRET returns to mepc.
    csr_mepc = 32'h400;
    ex_valid = 1'b1; mret_req = 1'b1;
    run_event("mret", 1'b1, 32'd0, 32'h400);

    // Flags raised during drain are dropped, but a held interrupt is taken on return to idle.
    csr_mie_global = 1'b1;
    ex_valid = 1'b1; exc_illegal = 1'b1; ex_pc = 32'h500; ex_inst = 32'hDEAD;
    step();
    clear_events();
    step();
    step();
    ex_valid = 1'b1; exc_illegal = 1'b1; irq_ext = 1'b1; ex_pc = 32'h600;
    repeat (D) step();
    check_eq("drain_no_stall_idle", 32'(flush), 32'd0);
    exc_illegal = 1'b0;
    run_event("held_irq", 1'b0, 32'h8000_000B, 32'h204);
    check_eq("held_irq_mepc", trap_mepc, 32'h600);

    // Reset in REDIRECT aborts the sequence; a fresh trap then completes normally.
    ex_valid = 1'b1; exc_load_mis = 1'b1; ex_mem_addr = 32'h77;
    step();
    clear_events();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("rst_mid_outs", {27'd0, stall, flush, pc_redirect, trap_we, mret_we}, 32'd0);
    check_eq("rst_mid_target", pc_target, 32'd0);
    step();
    ex_valid = 1'b1; exc_unsupported = 1'b1; ex_pc = 32'h800; ex_inst = 32'hABCD;
    run_event("after_reset", 1'b0, 32'd2, 32'h204);

    // Random phase: all expectations come from the timeline model.
    for (int i = 0; i < 3000; i++) begin
      reset           = ($urandom_range(0, 79) == 0);
      ex_valid        = ($urandom_range(0, 9) < 7);
      exc_unsupported = ($urandom_range(0, 15) == 0);
      exc_illegal     = ($urandom_range(0, 9) == 0);
      exc_load_mis    = ($urandom_range(0, 7) == 0);
      exc_store_mis   = ($urandom_range(0, 7) == 0);
      mret_req        = ($urandom_range(0, 5) == 0);
      irq_ext         = ($urandom_range(0, 5) == 0);
      csr_mie_global  = $urandom_range(0, 1);
      csr_meie        = $urandom_range(0, 1);
      ex_pc           = $urandom;
      ex_inst         = $urandom;
      ex_mem_addr     = $urandom;
      csr_mtvec       = $urandom;
      csr_mepc        = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
